hub75_rx: RTL and testbench

- Panel-side receiver for the HUB75 RGB matrix interface: the other end of the LED driver's A/B/C/D, R0/G0/B0, R1/G1/B1, OE, LAT and shift-clock outputs.
- Oversamples the HUB75 lines in the system clock domain and rebuilds each latched line into pixel-pair writes toward a frame buffer.
- Flags malformed lines, overruns and frame completion.
- Serves as the synthesizable checker/loopback sink for the LED driver on the board and in simulation.

---
 rtl/hub75_pkg.sv | 20 ++
 rtl/hub75_sync.sv | 32 +++
 rtl/hub75_rx.sv | 199 +++++++++++++++++++
 tb/tb_hub75_rx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_pkg.sv
// Shared types and defaults for the HUB75 panel-side receiver.
package hub75_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int ROW_BITS_DEF = 4;

    typedef logic [2:0] rgb_t;

    typedef struct packed {
        rgb_t rgb0;
        rgb_t rgb1;
    } pixel_pair_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/hub75_sync.sv
// Two-flop synchronizer with rising-edge detect on the synchronized copy.
module hub75_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);

    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;

    // synchronizer chain plus one history stage for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign q    = s2;
    assign rise = s2 & ~s3;

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receiver: captures shifted pixel pairs into a ping-pong bank pair
// and drains each latched line as pixel-pair writes toward a frame buffer.
//
// state | meaning
// IDLE  | no line pending, wr_en low
// DRAIN | presenting one column per accepted write, col 0..WIDTH-1
// DONE  | single cycle, line_done (and frame_done on last row)
import hub75_pkg::*;

module hub75_rx #(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int ROW_BITS    = ROW_BITS_DEF,
    parameter int COL_REVERSE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      hub_sclk,
    input  logic                      hub_lat,
    input  logic                      hub_oe,
    input  logic [ROW_BITS-1:0]       hub_addr,
    input  logic [2:0]                hub_rgb0,
    input  logic [2:0]                hub_rgb1,
    input  logic                      wr_ready,
    output logic                      wr_en,
    output logic [ROW_BITS-1:0]       wr_row,
    output logic [$clog2(WIDTH)-1:0]  wr_col,
    output logic [2:0]                wr_rgb0,
    output logic [2:0]                wr_rgb1,
    output logic                      line_done,
    output logic                      frame_done,
    output logic                      err_len,
    output logic                      err_ovr,
    output logic                      blank
);

    localparam int COL_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);

    logic [2:0]           ctrl_q;
    logic [2:0]           ctrl_rise;
    logic [ROW_BITS+5:0]  data_q;
    logic [ROW_BITS+5:0]  data_rise;
    logic                 unused_sync;

    logic                 sclk_evt;
    logic                 lat_evt;
    pixel_pair_t          pix_r;
    logic [ROW_BITS-1:0]  addr_r;

    pixel_pair_t          bank [2][WIDTH];
    logic                 sh_sel;
    logic [CNT_W-1:0]     sh_cnt;
    logic                 sh_ovf;
    logic [CNT_W-1:0]     cnt_next;
    logic                 ovf_next;
    logic                 shift_ok;
    logic                 len_ok;
    logic                 busy;
    logic                 start;

    logic [ROW_BITS-1:0]  line_row;
    logic [COL_W-1:0]     col;
    logic [COL_W-1:0]     rd_idx;
    pixel_pair_t          rd_pix;
    state_t               state_q;
    state_t               state_d;

    hub75_sync #(.W(3)) u_sync_ctrl (
        .clk  (clk),
        .rst  (rst),
        .d    ({hub_oe, hub_lat, hub_sclk}),
        .q    (ctrl_q),
        .rise (ctrl_rise)
    );

    hub75_sync #(.W(ROW_BITS + 6)) u_sync_data (
        .clk  (clk),
        .rst  (rst),
        .d    ({hub_addr, hub_rgb0, hub_rgb1}),
        .q    (data_q),
        .rise (data_rise)
    );

    // only the clock/latch edges and blank level are consumed from these groups
    assign unused_sync = ^{ctrl_q[1:0], data_rise};

    // register edges together with data/address so all stay cycle-aligned
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_evt <= 1'b0;
            lat_evt  <= 1'b0;
            pix_r    <= '0;
            addr_r   <= '0;
        end else begin
            sclk_evt <= ctrl_rise[0];
            lat_evt  <= ctrl_rise[1];
            pix_r    <= pixel_pair_t'(data_q[5:0]);
            addr_r   <= data_q[ROW_BITS+5:6];
        end
    end

    // a shift arriving in the latch cycle counts before the length check;
    // the overflow flag keeps a too-long line distinguishable from a full one
    always_comb begin
        shift_ok = sclk_evt && (sh_cnt != CNT_FULL);
        cnt_next = shift_ok ? sh_cnt + CNT_W'(1) : sh_cnt;
        ovf_next = sh_ovf | (sclk_evt && (sh_cnt == CNT_FULL));
        len_ok   = (cnt_next == CNT_FULL) && !ovf_next;
        busy     = (state_q != IDLE);
        start    = lat_evt && len_ok && !busy;
    end

    // shift bank write, indexed by shift order; column mapping happens on read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < WIDTH; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else if (shift_ok) begin
            bank[sh_sel][sh_cnt[COL_W-1:0]] <= pix_r;
        end
    end

    // shift counter, bank swap, row capture and error pulses on latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_cnt   <= '0;
            sh_ovf   <= 1'b0;
            sh_sel   <= 1'b0;
            line_row <= '0;
            err_len  <= 1'b0;
            err_ovr  <= 1'b0;
        end else begin
            err_len <= 1'b0;
            err_ovr <= 1'b0;
            if (lat_evt) begin
                sh_cnt  <= '0;
                sh_ovf  <= 1'b0;
                err_len <= !len_ok;
                err_ovr <= busy;
                if (start) begin
                    sh_sel   <= ~sh_sel;
                    line_row <= addr_r;
                end
            end else begin
                sh_cnt <= cnt_next;
                sh_ovf <= ovf_next;
            end
        end
    end

    // drain column advances only on accepted writes, wraps for the next line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
        end else if ((state_q == DRAIN) && wr_ready) begin
            col <= (col == COL_LAST) ? '0 : col + COL_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRAIN;
            DRAIN:   if (wr_ready && (col == COL_LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // drain-side read and write outputs; colours forced to 0 outside a drain
    always_comb begin
        rd_idx     = (COL_REVERSE != 0) ? COL_LAST - col : col;
        rd_pix     = bank[~sh_sel][rd_idx];
        wr_en      = (state_q == DRAIN);
        wr_row     = line_row;
        wr_col     = col;
        wr_rgb0    = wr_en ? rd_pix.rgb0 : 3'b000;
        wr_rgb1    = wr_en ? rd_pix.rgb1 : 3'b000;
        line_done  = (state_q == DONE);
        frame_done = line_done && (&line_row);
        blank      = ctrl_q[2];
    end

endmodule

// File: tb/tb_hub75_rx.sv
// Self-checking bench for hub75_rx: scoreboard of expected writes plus
// per-scenario pulse and count checks.
module tb_hub75_rx;
    import hub75_pkg::*;

    localparam int WIDTH    = 32;
    localparam int ROW_BITS = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                hub_sclk = 1'b0;
    logic                hub_lat = 1'b0;
    logic                hub_oe = 1'b0;
    logic [ROW_BITS-1:0] hub_addr = '0;
    logic [2:0]          hub_rgb0 = '0;
    logic [2:0]          hub_rgb1 = '0;
    logic                wr_ready = 1'b1;
    logic                wr_en;
    logic [ROW_BITS-1:0] wr_row;
    logic [4:0]          wr_col;
    logic [2:0]          wr_rgb0;
    logic [2:0]          wr_rgb1;
    logic                line_done;
    logic                frame_done;
    logic                err_len;
    logic                err_ovr;
    logic                blank;

    hub75_rx #(.WIDTH(WIDTH), .ROW_BITS(ROW_BITS), .COL_REVERSE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .hub_sclk   (hub_sclk),
        .hub_lat    (hub_lat),
        .hub_oe     (hub_oe),
        .hub_addr   (hub_addr),
        .hub_rgb0   (hub_rgb0),
        .hub_rgb1   (hub_rgb1),
        .wr_ready   (wr_ready),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_rgb0    (wr_rgb0),
        .wr_rgb1    (wr_rgb1),
        .line_done  (line_done),
        .frame_done (frame_done),
        .err_len    (err_len),
        .err_ovr    (err_ovr),
        .blank      (blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] row;
        logic [4:0] col;
        logic [2:0] rgb0;
        logic [2:0] rgb1;
    } wr_t;

    wr_t sb[$];
    wr_t exp_wr;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  n_line   = 0;
    int  n_frame  = 0;
    int  n_elen   = 0;
    int  n_eovr   = 0;
    logic [3:0] frame_row = '0;

    // monitor: accepted writes are popped against the scoreboard, pulses counted
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en && wr_ready) begin
                n_writes++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got row %0d col %0d rgb0 %0d rgb1 %0d, required no write",
                             wr_row, wr_col, wr_rgb0, wr_rgb1);
                end else begin
                    exp_wr = sb.pop_front();
                    if ({wr_row, wr_col, wr_rgb0, wr_rgb1} !== {exp_wr.row, exp_wr.col, exp_wr.rgb0, exp_wr.rgb1}) begin
                        n_fail++;
                        $display("FAIL write_data: got row %0d col %0d rgb0 %0d rgb1 %0d, required row %0d col %0d rgb0 %0d rgb1 %0d",
                                 wr_row, wr_col, wr_rgb0, wr_rgb1, exp_wr.row, exp_wr.col, exp_wr.rgb0, exp_wr.rgb1);
                    end
                end
            end
            if (line_done) n_line++;
            if (frame_done) begin
                n_frame++;
                frame_row = wr_row;
                n_checks++;
                if (line_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL frame_with_line: got line_done %b, required 1", line_done);
                end
            end
            if (err_len) n_elen++;
            if (err_ovr) n_eovr++;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic shift_pix(input logic [2:0] c0, input logic [2:0] c1);
        @(negedge clk);
        hub_rgb0 = c0;
        hub_rgb1 = c1;
        repeat (2) @(negedge clk);
        hub_sclk = 1'b1;
        repeat (3) @(negedge clk);
        hub_sclk = 1'b0;
    endtask

    task automatic shift_line(input int n, input logic [3:0] addr, input int seed);
        logic [2:0] v;
        @(negedge clk);
        hub_addr = addr;
        for (int k = 0; k < n; k++) begin
            v = 3'(k + seed);
            shift_pix(v, ~v);
        end
    endtask

    // expected drain order is column 0 upward; column c holds shift index 31-c
    task automatic push_line(input logic [3:0] addr, input int seed);
        logic [2:0] v;
        for (int c = 0; c < WIDTH; c++) begin
            v = 3'((WIDTH - 1 - c) + seed);
            sb.push_back('{addr, 5'(c), v, ~v});
        end
    endtask

    task automatic pulse_lat();
        @(negedge clk);
        hub_lat = 1'b1;
        repeat (3) @(negedge clk);
        hub_lat = 1'b0;
    endtask

    task automatic wait_line(input int base);
        for (int i = 0; i < 600 && n_line == base; i++) @(negedge clk);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({wr_en, wr_row, wr_col, wr_rgb0, wr_rgb1, line_done, frame_done, err_len, err_ovr, blank} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {wr_en, wr_row, wr_col, wr_rgb0, wr_rgb1, line_done, frame_done, err_len, err_ovr, blank});
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_blank();
        @(negedge clk);
        hub_oe = 1'b1;
        @(negedge clk);
        n_checks++;
        if (blank !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_delay1: got %b, required 0", blank);
        end
        @(negedge clk);
        n_checks++;
        if (blank !== 1'b1) begin
            n_fail++;
            $display("FAIL blank_delay2: got %b, required 1", blank);
        end
        hub_oe = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_line();
        int wb, lb, fb, eb;
        int first;
        wb = n_writes; lb = n_line; fb = n_frame; eb = n_elen;
        shift_line(32, 4'd5, 0);
        push_line(4'd5, 0);
        @(negedge clk);
        hub_lat = 1'b1;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (wr_en && first == 0) first = i;
            if (i == 3) hub_lat = 1'b0;
        end
        n_checks++;
        if (first !== 4) begin
            n_fail++;
            $display("FAIL good_latency: got first wr_en at cycle %0d, required 4", first);
        end
        wait_line(lb);
        n_checks++;
        if (n_writes - wb !== 32) begin
            n_fail++;
            $display("FAIL good_writes: got %0d, required 32", n_writes - wb);
        end
        n_checks++;
        if (n_line - lb !== 1) begin
            n_fail++;
            $display("FAIL good_line_done: got %0d, required 1", n_line - lb);
        end
        n_checks++;
        if (n_frame - fb !== 0 || n_elen - eb !== 0) begin
            n_fail++;
            $display("FAIL good_no_frame_err: got frame %0d err_len %0d, required 0 0", n_frame - fb, n_elen - eb);
        end
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL good_sb_empty: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_bad_length();
        int lens[2] = '{31, 33};
        int wb, eb, ob;
        foreach (lens[j]) begin
            wb = n_writes; eb = n_elen; ob = n_eovr;
            shift_line(lens[j], 4'd1, j);
            pulse_lat();
            repeat (12) @(negedge clk);
            n_checks++;
            if (n_elen - eb !== 1) begin
                n_fail++;
                $display("FAIL bad_len_%0d_err: got %0d pulses, required 1", lens[j], n_elen - eb);
            end
            n_checks++;
            if (n_writes - wb !== 0 || n_eovr - ob !== 0) begin
                n_fail++;
                $display("FAIL bad_len_%0d_quiet: got writes %0d err_ovr %0d, required 0 0", lens[j], n_writes - wb, n_eovr - ob);
            end
        end
    endtask

    task automatic test_backpressure();
        int wb, lb;
        logic [2:0] v;
        logic held_ok;
        wb = n_writes; lb = n_line;
        shift_line(32, 4'd9, 3);
        push_line(4'd9, 3);
        pulse_lat();
        for (int i = 0; i < 100 && !(wr_en && wr_col == 5'd11); i++) @(negedge clk);
        @(posedge clk);
        #1 wr_ready = 1'b0;
        v = 3'((WIDTH - 1 - 12) + 3);
        held_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({wr_en, wr_col, wr_rgb0, wr_rgb1} !== {1'b1, 5'd12, v, ~v}) held_ok = 1'b0;
        end
        n_checks++;
        if (held_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got wr_en %b col %0d rgb0 %0d rgb1 %0d, required 1 12 %0d %0d",
                     wr_en, wr_col, wr_rgb0, wr_rgb1, v, ~v);
        end
        @(posedge clk);
        #1 wr_ready = 1'b1;
        wait_line(lb);
        n_checks++;
        if (n_writes - wb !== 32) begin
            n_fail++;
            $display("FAIL bp_writes: got %0d, required 32", n_writes - wb);
        end
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL bp_sb_empty: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_overrun();
        int wb, lb, eb, ob, w_after;
        wb = n_writes; lb = n_line; eb = n_elen; ob = n_eovr;
        @(posedge clk);
        #1 wr_ready = 1'b0;
        shift_line(32, 4'd2, 1);
        push_line(4'd2, 1);
        pulse_lat();
        shift_line(32, 4'd3, 5);
        pulse_lat();
        repeat (10) @(negedge clk);
        n_checks++;
        if (n_eovr - ob !== 1 || n_elen - eb !== 0) begin
            n_fail++;
            $display("FAIL ovr_pulse: got err_ovr %0d err_len %0d, required 1 0", n_eovr - ob, n_elen - eb);
        end
        n_checks++;
        if (n_writes - wb !== 0 || wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_stalled: got writes %0d wr_en %b, required 0 1", n_writes - wb, wr_en);
        end
        @(posedge clk);
        #1 wr_ready = 1'b1;
        wait_line(lb);
        repeat (60) @(negedge clk);
        w_after = n_writes - wb;
        n_checks++;
        if (w_after !== 32 || n_line - lb !== 1) begin
            n_fail++;
            $display("FAIL ovr_first_only: got writes %0d lines %0d, required 32 1", w_after, n_line - lb);
        end
    endtask

    task automatic test_frame();
        int lb, fb;
        lb = n_line; fb = n_frame;
        for (int r = 0; r < 16; r++) begin
            shift_line(32, 4'(r), r);
            push_line(4'(r), r);
            pulse_lat();
            wait_line(n_line);
        end
        n_checks++;
        if (n_line - lb !== 16) begin
            n_fail++;
            $display("FAIL frame_lines: got %0d, required 16", n_line - lb);
        end
        n_checks++;
        if (n_frame - fb !== 1 || frame_row !== 4'd15) begin
            n_fail++;
            $display("FAIL frame_done: got %0d pulses at row %0d, required 1 at row 15", n_frame - fb, frame_row);
        end
    endtask

    task automatic test_reset_mid_drain();
        int wb, lb, eb;
        shift_line(32, 4'd3, 2);
        push_line(4'd3, 2);
        pulse_lat();
        for (int i = 0; i < 100 && !(wr_en && wr_col == 5'd5); i++) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        lb = n_line; eb = n_elen;
        @(negedge clk);
        n_checks++;
        if ({wr_en, wr_row, wr_col, wr_rgb0, wr_rgb1, line_done, frame_done, err_len, err_ovr, blank} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b, required all zero",
                     {wr_en, wr_row, wr_col, wr_rgb0, wr_rgb1, line_done, frame_done, err_len, err_ovr, blank});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (n_line - lb !== 0 || n_elen - eb !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got line_done %0d err_len %0d, required 0 0", n_line - lb, n_elen - eb);
        end
        wb = n_writes; lb = n_line;
        shift_line(32, 4'd7, 6);
        push_line(4'd7, 6);
        pulse_lat();
        wait_line(lb);
        n_checks++;
        if (n_writes - wb !== 32 || n_line - lb !== 1 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL midreset_recover: got writes %0d lines %0d pending %0d, required 32 1 0",
                     n_writes - wb, n_line - lb, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_blank();
        test_good_line();
        test_bad_length();
        test_backpressure();
        test_overrun();
        test_frame();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
